mandelbrot_collector: RTL and testbench
=======================================

// Module: mandelbrot_collector
// PURPOSE
// - N-to-1 merge of pixel result streams from up to NUM_PORTS mandelbrot_coord_feeder engines into one AVST stream for the pixel writer.
// - It is the return path of the work fan-out: each engine's result is arbitrated round-robin and registered once.
// - Each accepted result is counted against a per-frame expected count. Completion raises an interrupt.
// - AVMM slave for control and status.
// PARAMETERS
// - NUM_PORTS  12  number of sink ports, 1..16.
// - DATA_W     48  result vector width: pix_ptr[31:0] at [47:16], iters[15:0] at [15:0].
// PORTS
// - clk                   in   1                  clock.
// - reset                 in   1                  one clock; reset is synchronous and active-high.
// - sl_read               in   1                  AVMM read strobe.
// - sl_write              in   1                  AVMM write strobe.
// - sl_byteenable         in   4                  AVMM byte enables.
// - sl_address            in   3                  AVMM word address.
// - sl_writedata          in   32                 AVMM write data.
// - sl_readdata           out  32                 AVMM read data, registered.
// - sl_waitrequest        out  1                  tied 0.
// - sl_readdatavalid      out  1                  one-cycle pulse, 1 clk after sl_read.
// - interrupt_out         out  1                  int_pending & int_enable.
// - in_vector_snk_data    in   NUM_PORTS*DATA_W   port i at [i*DATA_W +: DATA_W].
// - in_vector_snk_valid   in   NUM_PORTS          per-port valid.
// - in_vector_snk_ready   out  NUM_PORTS          per-port ready, combinational from grant.
// - out_vector_src_data   out  DATA_W             registered output data.
// - out_vector_src_valid  out  1                  registered output valid.
// - out_vector_src_ready  in   1                  downstream ready.
// BEHAVIOUR
// - Reset values:
//   - Outputs: every output is 0 except sl_waitrequest (tied 0).
//   - Registers: enable=1, flush=0, int_enable=0, int_pending=0, expected=0, count=0, rr_ptr=0.
// - Load condition: load = ~out_valid | out_ready.
// - Requests: req = in_valid & enable & {NUM_PORTS{~flush}}.
//   - Exactly one grant, combinational. It is the first set req bit at or after rr_ptr, wrapping from NUM_PORTS-1 to 0.
// - Ready: in_ready[i] = grant[i] & load. At most one ready is high per cycle. Ready never depends on that port's own valid beyond the grant.
// - Transfer on port g (in_valid[g] & in_ready[g]):
//   - out_data <= in_data[g] and out_valid <= 1 on the next edge. Latency is 1 clk.
//   - rr_ptr <= g+1 mod NUM_PORTS.
// - No transfer while load=1: out_valid <= 0 on the next edge.
// - Backpressure: while out_valid & ~out_ready, out_data and out_valid hold, no sink is readied, and rr_ptr holds.
// - Throughput: one result per clk when downstream is always ready.
// - Flush=1:
//   - All in_ready = 1 and inputs are discarded.
//   - out_valid <= 0 on the next edge, including a stalled word, which is dropped.
//   - count is held.
// - Counting: count (32b) increments on each out_valid & out_ready.
//   - When expected != 0 and count+1 == expected on a handshake: int_pending <= 1 and count <= 0.
//   - expected == 0 disables the interrupt; count still wraps at 2^32.
// - int_clear:
//   - A write of bit0=1 to address 3 clears int_pending on that same edge.
//   - If a set and a clear coincide, the set wins.
// - Writing expected (address 4) also resets count to 0 on the same edge. A handshake on that edge is not counted.
// - Register map (word addresses), one write per cycle, byteenable honoured per byte:
//   - 0 enable[NUM_PORTS-1:0], RW. Bit0 is forced to 1.
//   - 1 flush[0], RW.
//   - 2 int_enable[0], RW.
//   - 3 int_clear, WO, reads 0.
//   - 4 expected[31:0], RW.
//   - 5 count[31:0], RO.
//   - 6 {int_pending, 15'd0, in_valid zero-extended to 16}, RO.
//   - 7 reads 0.
// - Disabling a port while it is being granted takes effect on the next cycle; an in-flight output word is not affected.
// - Reset mid-transfer: the output word is lost and count is zeroed. Upstream must re-issue the frame.
// STRUCTURE
// - Shared package mandelbrot_pkg: register address localparams (MC_ENABLE..MC_STATUS) and the result-vector field offsets.
// - Sub-module mandelbrot_rr_arbiter (NUM_PORTS):
//   - Inputs: req, rr_ptr. Output: one-hot grant plus encoded index.
//   - Purely combinational: a double-width mask-and-priority search.
// - Top: the AVMM register file, output register, counter and interrupt logic.
// TESTING
// - All ports enabled, all 12 valid continuously, out_ready=1 -> grants 0,1,...,11,0 on successive clks; 12 words out in 12 clks after a 1-clk latency.
// - Only port 0 enabled (enable=0x001), ports 0 and 5 valid -> only port 0 readied; port 5 in_ready stays 0.
// - Word from port 3 stalled, out_ready=0 for 4 clks -> out_data stable, all in_ready=0; word accepted on first ready clk.
// - expected=5, int_enable=1, 5 results drained -> interrupt_out rises 1 clk after the 5th handshake and count reads 0; int_clear at the same edge as a 2nd completion -> pending stays 1.
// - flush=1 with port 7 valid and a stalled output -> all ready=1, out_valid=0 next clk, count unchanged.
// - Write enable=0x000 -> readback 0x001; read -> sl_readdatavalid pulses exactly 1 clk later.

Source files
------------

// File: rtl/mandelbrot_pkg.sv
`default_nettype none
// ============================================================================
// Module : mandelbrot_pkg
// Brief  : Register map and result-vector field layout shared by the collector.
// Rev    : 1.0
// ============================================================================
package mandelbrot_pkg;

  localparam logic [2:0] MC_ENABLE     = 3'd0;
  localparam logic [2:0] MC_FLUSH      = 3'd1;
  localparam logic [2:0] MC_INT_ENABLE = 3'd2;
  localparam logic [2:0] MC_INT_CLEAR  = 3'd3;
  localparam logic [2:0] MC_EXPECTED   = 3'd4;
  localparam logic [2:0] MC_COUNT      = 3'd5;
  localparam logic [2:0] MC_STATUS     = 3'd6;

  localparam int RES_PIX_PTR_LSB = 16;
  localparam int RES_PIX_PTR_W   = 32;
  localparam int RES_ITERS_LSB   = 0;
  localparam int RES_ITERS_W     = 16;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = be[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mandelbrot_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mandelbrot_rr_arbiter
// Brief  : Combinational round-robin picker: first request at or after ptr.
// Rev    : 1.0
// ============================================================================
module mandelbrot_rr_arbiter #(
  parameter int NUM_PORTS = 12,
  parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx
);

  logic [2*NUM_PORTS-1:0] req2;
  logic                   found;

  // Doubling the request vector turns the wrap-around into a linear search.
  always_comb begin
    req2      = {req, req};
    found     = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < 2*NUM_PORTS; i++) begin
      if (!found && (i >= int'(rr_ptr)) && req2[i]) begin
        found     = 1'b1;
        grant_idx = IDX_W'(i % NUM_PORTS);
      end
    end
    grant = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      grant[j] = found && (int'(grant_idx) == j);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mandelbrot_collector.sv
`default_nettype none
// ============================================================================
// Module : mandelbrot_collector
// Brief  : N-to-1 round-robin merge of engine results with frame counting,
//          completion interrupt and AVMM control/status.
// Rev    : 1.0
// ============================================================================
module mandelbrot_collector
  import mandelbrot_pkg::*;
#(
  parameter int NUM_PORTS = 12,
  parameter int DATA_W    = 48
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sl_read,
  input  logic                      sl_write,
  input  logic [3:0]                sl_byteenable,
  input  logic [2:0]                sl_address,
  input  logic [31:0]               sl_writedata,
  output logic [31:0]               sl_readdata,
  output logic                      sl_waitrequest,
  output logic                      sl_readdatavalid,
  output logic                      interrupt_out,
  input  logic [NUM_PORTS*DATA_W-1:0] in_vector_snk_data,
  input  logic [NUM_PORTS-1:0]      in_vector_snk_valid,
  output logic [NUM_PORTS-1:0]      in_vector_snk_ready,
  output logic [DATA_W-1:0]         out_vector_src_data,
  output logic                      out_vector_src_valid,
  input  logic                      out_vector_src_ready
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0] enable;
  logic                 flush;
  logic                 int_enable;
  logic                 int_pending;
  logic [31:0]          expected;
  logic [31:0]          count;
  logic [IDX_W-1:0]     rr_ptr;

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] grant;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     ptr_next;
  logic                 load;
  logic                 xfer;
  logic                 handshake;
  logic                 frame_done;
  logic                 wr_enable, wr_flush, wr_int_en, wr_clear, wr_expected;
  logic [NUM_PORTS-1:0] enable_wr;
  logic [31:0]          rd_mux;
  logic [DATA_W-1:0]    sel_data;

  assign load      = ~out_vector_src_valid | out_vector_src_ready;
  assign req       = in_vector_snk_valid & enable & {NUM_PORTS{~flush}};
  assign xfer      = (|grant) & load;
  assign handshake = out_vector_src_valid & out_vector_src_ready & ~flush;
  assign frame_done = (expected != 32'd0) && ((count + 32'd1) == expected);
  assign ptr_next  = (grant_idx == IDX_W'(NUM_PORTS-1)) ? '0 : grant_idx + 1'b1;
  assign sel_data  = in_vector_snk_data[int'(grant_idx)*DATA_W +: DATA_W];

  assign in_vector_snk_ready = flush ? {NUM_PORTS{1'b1}} : (grant & {NUM_PORTS{load}});
  assign sl_waitrequest      = 1'b0;
  assign interrupt_out       = int_pending & int_enable;

  assign wr_enable   = sl_write && (sl_address == MC_ENABLE);
  assign wr_flush    = sl_write && (sl_address == MC_FLUSH) && sl_byteenable[0];
  assign wr_int_en   = sl_write && (sl_address == MC_INT_ENABLE) && sl_byteenable[0];
  assign wr_clear    = sl_write && (sl_address == MC_INT_CLEAR) && sl_byteenable[0]
                       && sl_writedata[0];
  assign wr_expected = sl_write && (sl_address == MC_EXPECTED);

  mandelbrot_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_arb (
    .req       (req),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Port 0 can never be disabled so the merge cannot be shut off entirely.
  always_comb begin
    enable_wr = enable;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sl_byteenable[i/8]) enable_wr[i] = sl_writedata[i];
    end
    enable_wr[0] = 1'b1;
  end

  always_comb begin
    rd_mux = 32'd0;
    case (sl_address)
      MC_ENABLE:     rd_mux = 32'(enable);
      MC_FLUSH:      rd_mux = {31'd0, flush};
      MC_INT_ENABLE: rd_mux = {31'd0, int_enable};
      MC_EXPECTED:   rd_mux = expected;
      MC_COUNT:      rd_mux = count;
      MC_STATUS:     rd_mux = {int_pending, 15'd0, 16'(in_vector_snk_valid)};
      default:       rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable               <= '1;
      flush                <= 1'b0;
      int_enable           <= 1'b0;
      int_pending          <= 1'b0;
      expected             <= 32'd0;
      count                <= 32'd0;
      rr_ptr               <= '0;
      out_vector_src_data  <= '0;
      out_vector_src_valid <= 1'b0;
      sl_readdata          <= 32'd0;
      sl_readdatavalid     <= 1'b0;
    end else begin
      if (wr_enable)   enable     <= enable_wr;
      if (wr_flush)    flush      <= sl_writedata[0];
      if (wr_int_en)   int_enable <= sl_writedata[0];
      if (wr_expected) expected   <= be_merge(expected, sl_writedata, sl_byteenable);

      // Flush drops even a stalled word; otherwise the register refills on load.
      if (flush) begin
        out_vector_src_valid <= 1'b0;
      end else if (load) begin
        out_vector_src_valid <= xfer;
        if (xfer) out_vector_src_data <= sel_data;
      end
      if (xfer) rr_ptr <= ptr_next;

      if (wr_expected) begin
        count <= 32'd0;
      end else if (handshake) begin
        count <= frame_done ? 32'd0 : count + 32'd1;
      end

      // A completion on the same edge as a clear keeps the interrupt pending.
      if (handshake && !wr_expected && frame_done) begin
        int_pending <= 1'b1;
      end else if (wr_clear) begin
        int_pending <= 1'b0;
      end

      sl_readdatavalid <= sl_read;
      if (sl_read) sl_readdata <= rd_mux;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mandelbrot_collector.sv
`default_nettype none
// ============================================================================
// Module : tb_mandelbrot_collector
// Brief  : Directed self-checking bench for the result-stream collector.
// Rev    : 1.0
// ============================================================================
module tb_mandelbrot_collector;

  localparam int NP = 12;
  localparam int DW = 48;

  logic              clk = 1'b0;
  logic              reset;
  logic              sl_read, sl_write;
  logic [3:0]        sl_byteenable;
  logic [2:0]        sl_address;
  logic [31:0]       sl_writedata;
  logic [31:0]       sl_readdata;
  logic              sl_waitrequest, sl_readdatavalid, interrupt_out;
  logic [NP*DW-1:0]  in_data;
  logic [NP-1:0]     in_valid, in_ready;
  logic [DW-1:0]     out_data;
  logic              out_valid, out_ready;

  int applied = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mandelbrot_collector #(.NUM_PORTS(NP), .DATA_W(DW)) dut (
    .clk                  (clk),
    .reset                (reset),
    .sl_read              (sl_read),
    .sl_write             (sl_write),
    .sl_byteenable        (sl_byteenable),
    .sl_address           (sl_address),
    .sl_writedata         (sl_writedata),
    .sl_readdata          (sl_readdata),
    .sl_waitrequest       (sl_waitrequest),
    .sl_readdatavalid     (sl_readdatavalid),
    .interrupt_out        (interrupt_out),
    .in_vector_snk_data   (in_data),
    .in_vector_snk_valid  (in_valid),
    .in_vector_snk_ready  (in_ready),
    .out_vector_src_data  (out_data),
    .out_vector_src_valid (out_valid),
    .out_vector_src_ready (out_ready)
  );

  function automatic logic [DW-1:0] dat(input int i);
    return {32'h1000_0000 + 32'(i), 16'h0100 + 16'(i)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    applied++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    sl_write = 1'b1; sl_address = a; sl_writedata = d; sl_byteenable = be;
    tick();
    sl_write = 1'b0; sl_byteenable = 4'h0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    sl_read = 1'b1; sl_address = a;
    tick();
    sl_read = 1'b0;
    chk({tag, "_rdv"}, 64'(sl_readdatavalid), 64'd1);
    chk(tag, 64'(sl_readdata), 64'(exp));
    tick();
    chk({tag, "_rdv_end"}, 64'(sl_readdatavalid), 64'd0);
  endtask

  initial begin
    reset = 1'b1; sl_read = 1'b0; sl_write = 1'b0; sl_byteenable = 4'h0;
    sl_address = 3'd0; sl_writedata = 32'd0; in_valid = '0; out_ready = 1'b1;
    for (int i = 0; i < NP; i++) in_data[i*DW +: DW] = dat(i);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_irq", 64'(interrupt_out), 64'd0);
    chk("rst_waitreq", 64'(sl_waitrequest), 64'd0);
    chk("rst_readdata", 64'(sl_readdata), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    tick();
    rd(3'd5, 32'd0, "rst_count");
    rd(3'd4, 32'd0, "rst_expected");
    wr(3'd0, 32'h0000_0FFF, 4'hF);

    // Round robin across all ports with downstream always ready.
    in_valid = '1;
    for (int k = 0; k < NP; k++) begin
      #1;
      chk($sformatf("rr_ready_%0d", k), 64'(in_ready), 64'(12'd1 << k));
      tick();
      chk($sformatf("rr_valid_%0d", k), 64'(out_valid), 64'd1);
      chk($sformatf("rr_data_%0d", k), 64'(out_data), 64'(dat(k)));
    end
    #1;
    chk("rr_wrap_ready", 64'(in_ready), 64'h001);
    tick();
    chk("rr_wrap_data", 64'(out_data), 64'(dat(0)));
    in_valid = '0;
    tick();
    chk("rr_drain_valid", 64'(out_valid), 64'd0);
    rd(3'd5, 32'd13, "rr_count");

    // Only port 0 enabled: port 5 must never be readied.
    wr(3'd0, 32'h0000_0001, 4'hF);
    in_valid = 12'h021;
    #1;
    chk("en_ready", 64'(in_ready), 64'h001);
    tick();
    chk("en_data", 64'(out_data), 64'(dat(0)));
    chk("en_ready2", 64'(in_ready), 64'h001);
    in_valid = '0;
    tick();
    wr(3'd0, 32'h0000_0000, 4'hF);
    rd(3'd0, 32'h0000_0001, "en_force_bit0");
    wr(3'd0, 32'h0000_0FFF, 4'h1);
    rd(3'd0, 32'h0000_00FF, "en_byteenable");
    wr(3'd0, 32'h0000_0FFF, 4'hF);

    // Port 3 word held under backpressure.
    wr(3'd4, 32'd0, 4'hF);
    out_ready = 1'b0;
    in_valid = 12'h008;
    #1;
    chk("stall_ready0", 64'(in_ready), 64'h008);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stall_valid_%0d", k), 64'(out_valid), 64'd1);
      chk($sformatf("stall_data_%0d", k), 64'(out_data), 64'(dat(3)));
      chk($sformatf("stall_ready_%0d", k), 64'(in_ready), 64'd0);
      tick();
    end
    in_valid = '0;
    out_ready = 1'b1;
    tick();
    chk("stall_accepted", 64'(out_valid), 64'd0);
    rd(3'd5, 32'd1, "stall_count");

    // Frame completion interrupt.
    wr(3'd2, 32'd1, 4'hF);
    wr(3'd4, 32'd5, 4'hF);
    in_valid = 12'h001;
    for (int k = 0; k < 5; k++) tick();
    in_valid = '0;
    chk("irq_before", 64'(interrupt_out), 64'd0);
    tick();
    chk("irq_raised", 64'(interrupt_out), 64'd1);
    rd(3'd5, 32'd0, "irq_count");
    rd(3'd6, 32'h8000_0000, "irq_status");
    in_valid = 12'h001;
    for (int k = 0; k < 5; k++) tick();
    in_valid = '0;
    wr(3'd3, 32'd1, 4'hF);
    chk("irq_set_wins", 64'(interrupt_out), 64'd1);
    wr(3'd3, 32'd1, 4'hF);
    chk("irq_cleared", 64'(interrupt_out), 64'd0);
    rd(3'd3, 32'd0, "int_clear_reads0");

    // Flush drops a stalled port-7 word and readies every sink.
    out_ready = 1'b0;
    in_valid = 12'h080;
    tick();
    chk("fl_stalled", 64'(out_data), 64'(dat(7)));
    wr(3'd1, 32'd1, 4'hF);
    chk("fl_ready_all", 64'(in_ready), 64'hFFF);
    tick();
    chk("fl_drop", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("fl_discard", 64'(out_valid), 64'd0);
    rd(3'd5, 32'd0, "fl_count");
    wr(3'd1, 32'd0, 4'hF);
    in_valid = '0;
    rd(3'd7, 32'd0, "addr7");

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
